// File: rtl/systolic_writeback.sv
// -----------------------------------------------------------------------------
// systolic_writeback
//   Downstream stage of the systolic matmul core. On a start request it checks
//   the request, snapshots the N x N result matrix (with optional ReLU) and
//   writes the top-left n x n region row-major to data memory starting at
//   base_addr. It supports memory back-pressure (mem_ready) and a single-step
//   mode, and keeps a saturating count of accepted writes.
//
// Ports
//   clk             : system clock, rising edge
//   rst             : synchronous reset, active-low
//   start           : one-cycle request, only looked at in IDLE
//   matrix_C        : signed N x N results, valid in the start cycle
//   base_addr       : destination base address (12 bit)
//   n               : active dimension (9 bit)
//   relu_en         : 1 = negative elements are written as zero
//   stepping_enable : 1 = issue a write only in cycles with step=1
//   step            : single-step strobe
//   mem_ready       : memory accepts the write this cycle
//   mem_write       : write request
//   mem_addr        : write address
//   mem_data_write  : signed write data
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse after the last element is accepted
//   error           : one-cycle pulse when a request is rejected
//   writes_count    : cumulative accepted writes, saturating
// -----------------------------------------------------------------------------
module systolic_writeback #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] matrix_C [N][N],
  input  logic        [11:0]      base_addr,
  input  logic        [8:0]       n,
  input  logic                    relu_en,
  input  logic                    stepping_enable,
  input  logic                    step,
  input  logic                    mem_ready,
  output logic                    mem_write,
  output logic        [11:0]      mem_addr,
  output logic signed [WIDTH-1:0] mem_data_write,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic        [31:0]      writes_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic signed [WIDTH-1:0] buf_r [N][N];
  logic [IDX_W-1:0]        i_r;
  logic [IDX_W-1:0]        j_r;
  logic [8:0]              n_r;
  logic [11:0]             addr_r;
  logic [31:0]             count_r;
  logic                    issue_s;
  logic                    accept_s;
  logic                    row_end_s;
  logic                    last_s;
  logic                    req_bad_s;
  logic [31:0]             req_end_s;

  // ReLU clamp applied while snapshotting the matrix
  function automatic logic signed [WIDTH-1:0] relu_f(
    input logic signed [WIDTH-1:0] v,
    input logic                    en
  );
    if (en && v[WIDTH-1]) begin
      return {WIDTH{1'b0}};
    end else begin
      return v;
    end
  endfunction

  // Request validation: empty, oversize, or region running past address 4095.
  // base + n*n - 1 > 4095 is evaluated as base + n*n > 4096 to avoid underflow.
  always_comb begin
    req_end_s = 32'(base_addr) + (32'(n) * 32'(n));
    req_bad_s = (n == 9'd0) || (n > 9'(N)) || (req_end_s > 32'd4096);
  end

  // Position decode within the active region
  always_comb begin
    row_end_s = (9'(j_r) == (n_r - 9'd1));
    last_s    = row_end_s && (9'(i_r) == (n_r - 9'd1));
  end

  // Next-state and write-issue logic
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = req_bad_s ? ST_ERROR : ST_WRITE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        issue_s = !stepping_enable || step;
        if (issue_s && mem_ready && last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      ST_ERROR: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  assign accept_s = issue_s && mem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot buffer, element indices, running address and write counter.
  // The address simply increments per accepted write: row-major order over an
  // n x n region with stride n is contiguous.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_r[r][c] <= {WIDTH{1'b0}};
        end
      end
      i_r     <= {IDX_W{1'b0}};
      j_r     <= {IDX_W{1'b0}};
      n_r     <= 9'd0;
      addr_r  <= 12'd0;
      count_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !req_bad_s) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                buf_r[r][c] <= relu_f(matrix_C[r][c], relu_en);
              end
            end
            i_r    <= {IDX_W{1'b0}};
            j_r    <= {IDX_W{1'b0}};
            n_r    <= n;
            addr_r <= base_addr;
          end else begin
            n_r <= n_r;
          end
        end
        ST_WRITE: begin
          if (accept_s) begin
            if (count_r != 32'hFFFF_FFFF) begin
              count_r <= count_r + 32'd1;
            end else begin
              count_r <= count_r;
            end
            addr_r <= addr_r + 12'd1;
            if (row_end_s) begin
              j_r <= {IDX_W{1'b0}};
              i_r <= i_r + IDX_W'(1);
            end else begin
              j_r <= j_r + IDX_W'(1);
            end
          end else begin
            addr_r <= addr_r;
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  assign mem_write      = issue_s;
  assign mem_addr       = addr_r;
  assign mem_data_write = buf_r[i_r][j_r];
  assign busy           = (state_r != ST_IDLE);
  assign done           = (state_r == ST_DONE);
  assign error          = (state_r == ST_ERROR);
  assign writes_count   = count_r;

endmodule

// File: tb/tb_systolic_writeback.sv
// -----------------------------------------------------------------------------
// tb_systolic_writeback
//   Directed bench for systolic_writeback: a table of single-shot transfers
//   plus hand-written sequences for back-pressure, single-step with an ignored
//   mid-transfer start, and reset during a transfer.
// -----------------------------------------------------------------------------
module tb_systolic_writeback;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [15:0]  mat [4][4];
  logic        [11:0]  base_in;
  logic        [8:0]   n_in;
  logic                relu;
  logic                stepping;
  logic                step;
  logic                ready;
  logic                mem_write;
  logic        [11:0]  mem_addr;
  logic signed [15:0]  mem_data;
  logic                busy;
  logic                done;
  logic                error;
  logic        [31:0]  wcount;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  systolic_writeback #(.N(4), .WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .matrix_C        (mat),
    .base_addr       (base_in),
    .n               (n_in),
    .relu_en         (relu),
    .stepping_enable (stepping),
    .step            (step),
    .mem_ready       (ready),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_data_write  (mem_data),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .writes_count    (wcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]         n;
    logic [11:0]        base;
    logic               relu;
    logic               exp_err;
    int                 exp_done;
    logic signed [15:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference element value: C[i][j] = i*4 + j - 5, optionally clamped
  function automatic int model(input int i, input int j, input logic en);
    int v;
    v = i * 4 + j - 5;
    if (en && v < 0) v = 0;
    return v;
  endfunction

  task automatic set_pattern();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat[i][j] = 16'(i * 4 + j - 5);
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat[i][j] = 16'sh7777;
  endtask

  // mode 0: ready always; mode 1: ready low on odd cycles;
  // mode 2: stepping, step every 3rd cycle, junk start pulsed at cycle 4
  task automatic do_xfer(input logic [8:0] tn, input logic [11:0] tbase, input logic trelu,
                         input int mode, input logic texp_err, input int texp_done,
                         input logic signed [15:0] texp_last);
    int k = 0;
    int nn;
    int done_cyc = -1;
    int err_cyc = -1;
    int ndone = 0;
    int nerr = 0;
    logic signed [15:0] lastd = 16'sd0;
    logic exp_mw;
    nn = int'(tn) * int'(tn);
    set_pattern();
    n_in = tn; base_in = tbase; relu = trelu;
    stepping = (mode == 2); step = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    n_in = 9'd1; base_in = 12'hABC; relu = ~trelu;
    for (int c = 1; c <= 60; c++) begin
      ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
      step  = (mode == 2) && (c % 3 == 0);
      start = (mode == 2) && (c == 4);
      #1;
      exp_mw = ((mode == 2) ? step : 1'b1) && !texp_err && (k < nn);
      chk($sformatf("mem_write c%0d", c), 32'(mem_write), 32'(exp_mw));
      if (c == 1) chk("busy_c1", 32'(busy), 32'd1);
      if (mem_write) begin
        chk($sformatf("addr k%0d", k), 32'(mem_addr), 32'(tbase) + 32'(k));
        if (nn > 0)
          chk($sformatf("data k%0d", k), 32'(mem_data), 32'(model(k / int'(tn), k % int'(tn), trelu)));
        if (ready) begin
          lastd = mem_data;
          k++;
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        chk("busy_at_done", 32'(busy), 32'd1);
      end
      if (error) begin
        nerr++;
        if (err_cyc < 0) err_cyc = c;
      end
      tick();
    end
    start = 1'b0; step = 1'b0; stepping = 1'b0; ready = 1'b1;
    if (!texp_err) exp_cnt += nn;
    chk("writes", 32'(k), texp_err ? 32'd0 : 32'(nn));
    chk("done_cycle", 32'(done_cyc), 32'(texp_done));
    chk("done_pulses", 32'(ndone), texp_err ? 32'd0 : 32'd1);
    chk("error_cycle", 32'(err_cyc), texp_err ? 32'd1 : 32'hFFFF_FFFF);
    chk("error_pulses", 32'(nerr), texp_err ? 32'd1 : 32'd0);
    chk("writes_count", wcount, 32'(exp_cnt));
    chk("idle_after", 32'(busy), 32'd0);
    if (!texp_err) chk("last_data", 32'(lastd), 32'(texp_last));
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{9'd4, 12'd32,   1'b0, 1'b0, 17, 16'sd10};
    vecs[1] = '{9'd4, 12'd32,   1'b1, 1'b0, 17, 16'sd10};
    vecs[2] = '{9'd0, 12'd0,    1'b0, 1'b1, -1, 16'sd0};
    vecs[3] = '{9'd5, 12'd0,    1'b0, 1'b1, -1, 16'sd0};
    vecs[4] = '{9'd4, 12'd4090, 1'b0, 1'b1, -1, 16'sd0};
    vecs[5] = '{9'd4, 12'd4080, 1'b0, 1'b0, 17, 16'sd10};
    vecs[6] = '{9'd1, 12'd7,    1'b0, 1'b0, 2,  -16'sd5};
    vecs[7] = '{9'd3, 12'd4087, 1'b1, 1'b0, 10, 16'sd5};

    rst = 1'b0; start = 1'b0; base_in = 12'd0; n_in = 9'd0; relu = 1'b0;
    stepping = 1'b0; step = 1'b0; ready = 1'b1;
    set_pattern();
    tick();
    tick();
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_data", 32'(mem_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst count", wcount, 32'd0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      do_xfer(vecs[v].n, vecs[v].base, vecs[v].relu, 0,
              vecs[v].exp_err, vecs[v].exp_done, vecs[v].exp_last);
    end

    // Back-pressure: ready low every other cycle
    do_xfer(9'd2, 12'd100, 1'b0, 1, 1'b0, 9, 16'sd0);
    // Single-step, one step every 3 cycles, junk start mid-transfer
    do_xfer(9'd2, 12'd200, 1'b0, 2, 1'b0, 13, 16'sd0);

    // Reset after 5 accepted writes
    set_pattern();
    n_in = 9'd4; base_in = 12'd300; relu = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("abort mem_write c%0d", c), 32'(mem_write), 32'd1);
      chk($sformatf("abort addr c%0d", c), 32'(mem_addr), 32'd300 + 32'(c - 1));
      tick();
    end
    rst = 1'b0;
    tick();
    #1;
    chk("abort mem_write", 32'(mem_write), 32'd0);
    chk("abort mem_addr", 32'(mem_addr), 32'd0);
    chk("abort mem_data", 32'(mem_data), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort error", 32'(error), 32'd0);
    chk("abort count", wcount, 32'd0);
    rst = 1'b1;
    exp_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk("post_abort done", 32'(done), 32'd0);
      chk("post_abort busy", 32'(busy), 32'd0);
      chk("post_abort mem_write", 32'(mem_write), 32'd0);
    end
    do_xfer(9'd4, 12'd300, 1'b0, 0, 1'b0, 17, 16'sd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
